// File: rtl/gf12_pad_bank_ctrl_if.sv
// Core-side handshake bundle for gf12_pad_bank_ctrl: direction and
// configuration request channels with their ready/status returns.
interface gf12_pad_bank_ctrl_if;
    logic       dir_valid;
    logic       dir_req;
    logic       dir_ready;
    logic       dir_out;
    logic       cfg_valid;
    logic [1:0] cfg_ds;
    logic       cfg_sr;
    logic       cfg_ready;

    modport master (
        output dir_valid, dir_req, cfg_valid, cfg_ds, cfg_sr,
        input  dir_ready, dir_out, cfg_ready
    );

    modport slave (
        input  dir_valid, dir_req, cfg_valid, cfg_ds, cfg_sr,
        output dir_ready, dir_out, cfg_ready
    );
endinterface

// File: rtl/gf12_pad_bank_ctrl.sv
// Registered control stage for a bank of GF12 bidirectional pads with dead-cycle turnarounds.
// Optional PAD_BANK_GLITCH_FILTER_EN adds a 3-sample agreement filter on the input path.
module gf12_pad_bank_ctrl #(
    parameter int         NPADS       = 8,
    parameter int         TURN_CYCLES = 2,
    parameter logic [1:0] DS_RESET    = 2'b01,
    parameter logic       SR_RESET    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPADS-1:0]     out_data,
    output logic [NPADS-1:0]     in_data,
    gf12_pad_bank_ctrl_if.slave  ctl,
    output logic [NPADS-1:0]     pad_a,
    output logic [NPADS-1:0]     pad_oe,
    output logic [NPADS-1:0]     pad_ie,
    output logic [NPADS-1:0]     pad_ds0,
    output logic [NPADS-1:0]     pad_ds1,
    output logic [NPADS-1:0]     pad_sr,
    input  logic [NPADS-1:0]     pad_y
);

    typedef enum logic [1:0] {
        S_IN,
        S_TURN_OUT,
        S_OUT,
        S_TURN_IN
    } state_e;

`ifdef PAD_BANK_GLITCH_FILTER_EN
    localparam int QUAL = 4;
`else
    localparam int QUAL = 2;
`endif
    localparam logic [3:0] TURN = 4'(TURN_CYCLES);
    localparam logic [2:0] QMAX = 3'(QUAL - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             oe_q, ie_q;
    logic [1:0]       ds_q;
    logic             sr_q;
    logic [NPADS-1:0] a_q;
    logic [NPADS-1:0] s1_q, s2_q;
    logic [NPADS-1:0] in_q, in_d;
    logic [2:0]       qual_q, qual_d;
    logic             dir_hs;
    logic             cfg_hs;
    logic             upd;

    assign ctl.dir_ready = (state_q == S_IN) || (state_q == S_OUT);
    assign ctl.cfg_ready = (state_q != S_OUT);
    assign ctl.dir_out   = (state_q == S_OUT);

    assign dir_hs = ctl.dir_valid && ctl.dir_ready;
    assign cfg_hs = ctl.cfg_valid && ctl.cfg_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IN: begin
                if (dir_hs && ctl.dir_req) begin
                    state_d = S_TURN_OUT;
                    cnt_d   = TURN;
                end
            end
            S_TURN_OUT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_OUT;
                    cnt_d   = 4'd0;
                end
            end
            S_OUT: begin
                if (dir_hs && !ctl.dir_req) begin
                    state_d = S_TURN_IN;
                    cnt_d   = TURN;
                end
            end
            S_TURN_IN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_IN;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Input qualification: count cycles since IE rose, saturating at QUAL-1.
    always_comb begin
        qual_d = qual_q;
        if (!ie_q) begin
            qual_d = 3'd0;
        end else if (qual_q != QMAX) begin
            qual_d = qual_q + 3'd1;
        end
    end

    assign upd = ie_q && (qual_q == QMAX);

`ifdef PAD_BANK_GLITCH_FILTER_EN
    logic [NPADS-1:0] h1_q, h2_q;
    logic [NPADS-1:0] agree;

    assign agree = ~(s2_q ^ h1_q) & ~(s2_q ^ h2_q);

    always_comb begin
        in_d = in_q;
        if (upd) begin
            in_d = (s2_q & agree) | (in_q & ~agree);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q <= '0;
            h2_q <= '0;
        end else begin
            h1_q <= s2_q;
            h2_q <= h1_q;
        end
    end
`else
    always_comb begin
        in_d = in_q;
        if (upd) begin
            in_d = s2_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IN;
            cnt_q   <= 4'd0;
            oe_q    <= 1'b0;
            ie_q    <= 1'b1;
            ds_q    <= DS_RESET;
            sr_q    <= SR_RESET;
            a_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            in_q    <= '0;
            qual_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oe_q    <= (state_d == S_OUT);
            ie_q    <= (state_d == S_IN);
            if (cfg_hs) begin
                ds_q <= ctl.cfg_ds;
                sr_q <= ctl.cfg_sr;
            end
            a_q     <= out_data;
            s1_q    <= pad_y;
            s2_q    <= s1_q;
            in_q    <= in_d;
            qual_q  <= qual_d;
        end
    end

    // Per-pad pins are fanouts of single bank-wide flops.
    assign pad_a   = a_q;
    assign pad_oe  = {NPADS{oe_q}};
    assign pad_ie  = {NPADS{ie_q}};
    assign pad_ds0 = {NPADS{ds_q[0]}};
    assign pad_ds1 = {NPADS{ds_q[1]}};
    assign pad_sr  = {NPADS{sr_q}};
    assign in_data = in_q;

endmodule

// File: tb/tb_gf12_pad_bank_ctrl.sv
// Scoreboard bench for gf12_pad_bank_ctrl: stimulus queues timed expectations,
// a negedge monitor compares them against the pad pins and status outputs.
module tb_gf12_pad_bank_ctrl;

`ifdef PAD_BANK_GLITCH_FILTER_EN
    localparam int LAT  = 5;
    localparam int QUAL = 4;
`else
    localparam int LAT  = 3;
    localparam int QUAL = 2;
`endif

    typedef enum int {
        F_OE, F_IE, F_A, F_DS0, F_DS1, F_SR,
        F_IN, F_DRDY, F_CRDY, F_DOUT
    } fld_e;

    typedef struct {
        int         due;
        fld_e       f;
        logic [7:0] v;
        string      n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] out_data;
    logic [7:0] in_data;
    logic [7:0] pad_a, pad_oe, pad_ie;
    logic [7:0] pad_ds0, pad_ds1, pad_sr;
    logic [7:0] pad_y;

    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    gf12_pad_bank_ctrl_if bus ();

    gf12_pad_bank_ctrl #(
        .NPADS       (8),
        .TURN_CYCLES (2),
        .DS_RESET    (2'b01),
        .SR_RESET    (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_data (out_data),
        .in_data  (in_data),
        .ctl      (bus),
        .pad_a    (pad_a),
        .pad_oe   (pad_oe),
        .pad_ie   (pad_ie),
        .pad_ds0  (pad_ds0),
        .pad_ds1  (pad_ds1),
        .pad_sr   (pad_sr),
        .pad_y    (pad_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] act(fld_e f);
        case (f)
            F_OE:    return pad_oe;
            F_IE:    return pad_ie;
            F_A:     return pad_a;
            F_DS0:   return pad_ds0;
            F_DS1:   return pad_ds1;
            F_SR:    return pad_sr;
            F_IN:    return in_data;
            F_DRDY:  return {7'd0, bus.dir_ready};
            F_CRDY:  return {7'd0, bus.cfg_ready};
            default: return {7'd0, bus.dir_out};
        endcase
    endfunction

    task automatic expect_at(int d, fld_e f, logic [7:0] v, string n);
        exp_t e;
        e.due = cyc + d;
        e.f   = f;
        e.v   = v;
        e.n   = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: compare every entry that falls due at this negedge.
    int mi;
    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].due == cyc) begin
                tests++;
                if (act(sb[mi].f) !== sb[mi].v) begin
                    failed++;
                    $display("FAIL %s @cyc %0d: got %h want %h",
                             sb[mi].n, cyc, act(sb[mi].f), sb[mi].v);
                end
                sb.delete(mi);
            end else if (sb[mi].due < cyc) begin
                tests++;
                failed++;
                $display("FAIL %s: check missed (due %0d, now %0d) got %h want %h",
                         sb[mi].n, sb[mi].due, cyc, act(sb[mi].f), sb[mi].v);
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        out_data      = 8'h00;
        pad_y         = 8'h00;
        bus.dir_valid = 1'b0;
        bus.dir_req   = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ds    = 2'b00;
        bus.cfg_sr    = 1'b0;

        // Reset state
        step();
        expect_at(1, F_OE,   8'h00, "rst_oe");
        expect_at(1, F_IE,   8'hFF, "rst_ie");
        expect_at(1, F_DS0,  8'hFF, "rst_ds0");
        expect_at(1, F_DS1,  8'h00, "rst_ds1");
        expect_at(1, F_SR,   8'h00, "rst_sr");
        expect_at(1, F_IN,   8'h00, "rst_in");
        expect_at(1, F_A,    8'h00, "rst_a");
        expect_at(1, F_DRDY, 8'h01, "rst_drdy");
        expect_at(1, F_CRDY, 8'h01, "rst_crdy");
        expect_at(1, F_DOUT, 8'h00, "rst_dout");
        step();
        step();
        rst = 1'b0;
        repeat (4) step();

        // Input latency and output data latency
        pad_y    = 8'hA5;
        out_data = 8'h3C;
        expect_at(LAT - 1, F_IN, 8'h00, "in_lat_early");
        expect_at(LAT,     F_IN, 8'hA5, "in_lat");
        expect_at(1,       F_A,  8'h3C, "a_lat");
        repeat (LAT + 1) step();

        // Turn to output
        bus.dir_valid = 1'b1;
        bus.dir_req   = 1'b1;
        expect_at(1, F_IE,   8'h00, "to_out_ie_k");
        expect_at(1, F_OE,   8'h00, "to_out_oe_k");
        expect_at(1, F_DRDY, 8'h00, "to_out_drdy_k");
        expect_at(2, F_OE,   8'h00, "to_out_oe_k1");
        expect_at(2, F_DRDY, 8'h00, "to_out_drdy_k1");
        expect_at(2, F_DOUT, 8'h00, "to_out_dout_k1");
        expect_at(3, F_OE,   8'hFF, "to_out_oe_k2");
        expect_at(3, F_A,    8'h3C, "to_out_a_k2");
        expect_at(3, F_DRDY, 8'h01, "to_out_drdy_k2");
        expect_at(3, F_DOUT, 8'h01, "to_out_dout_k2");
        step();
        bus.dir_valid = 1'b0;
        repeat (3) step();

        // Config blocked while driving
        bus.cfg_valid = 1'b1;
        bus.cfg_ds    = 2'b11;
        bus.cfg_sr    = 1'b1;
        pad_y         = 8'h0F;
        expect_at(1, F_CRDY, 8'h00, "cfg_blk_rdy");
        expect_at(2, F_DS1,  8'h00, "cfg_blk_ds1");
        expect_at(2, F_DS0,  8'hFF, "cfg_blk_ds0");
        expect_at(2, F_SR,   8'h00, "cfg_blk_sr");
        expect_at(2, F_IN,   8'hA5, "in_hold_out");
        step();
        step();

        // Turn to input; pending cfg lands one edge after TURN_IN entry
        bus.dir_valid = 1'b1;
        bus.dir_req   = 1'b0;
        expect_at(1, F_OE,   8'h00, "to_in_oe_k");
        expect_at(1, F_CRDY, 8'h01, "to_in_crdy_k");
        expect_at(1, F_DS1,  8'h00, "to_in_ds1_k");
        expect_at(2, F_DS1,  8'hFF, "cfg_ok_ds1");
        expect_at(2, F_DS0,  8'hFF, "cfg_ok_ds0");
        expect_at(2, F_SR,   8'hFF, "cfg_ok_sr");
        expect_at(2, F_IE,   8'h00, "to_in_ie_k1");
        expect_at(3, F_IE,   8'hFF, "to_in_ie_k2");
        expect_at(2 + QUAL, F_IN, 8'hA5, "in_resume_early");
        expect_at(3 + QUAL, F_IN, 8'h0F, "in_resume");
        step();
        bus.dir_valid = 1'b0;
        step();
        bus.cfg_valid = 1'b0;
        repeat (QUAL + 3) step();

        // Same-direction request is a no-op
        bus.dir_valid = 1'b1;
        bus.dir_req   = 1'b0;
        expect_at(1, F_DRDY, 8'h01, "noop_drdy");
        expect_at(1, F_IE,   8'hFF, "noop_ie");
        expect_at(1, F_DOUT, 8'h00, "noop_dout");
        expect_at(2, F_IE,   8'hFF, "noop_ie2");
        expect_at(2, F_OE,   8'h00, "noop_oe2");
        step();
        bus.dir_valid = 1'b0;
        repeat (2) step();

        // Two-cycle pulse on pad_y[0]
        pad_y = 8'h0E;
`ifdef PAD_BANK_GLITCH_FILTER_EN
        for (int i = 3; i <= 7; i++) expect_at(i, F_IN, 8'h0F, "glitch_blocked");
`else
        expect_at(3, F_IN, 8'h0E, "pulse_pass0");
        expect_at(4, F_IN, 8'h0E, "pulse_pass1");
        expect_at(5, F_IN, 8'h0F, "pulse_end");
`endif
        step();
        step();
        pad_y = 8'h0F;
        repeat (8) step();

        // Stable change on pad_y[0]
        pad_y = 8'h0E;
        expect_at(LAT - 1, F_IN, 8'h0F, "stable_early");
        expect_at(LAT,     F_IN, 8'h0E, "stable_upd");
        repeat (LAT + 2) step();

        // Reset in the middle of TURN_OUT
        out_data      = 8'h5A;
        bus.dir_valid = 1'b1;
        bus.dir_req   = 1'b1;
        expect_at(1, F_OE, 8'h00, "mid_oe_k");
        expect_at(1, F_IE, 8'h00, "mid_ie_k");
        step();
        bus.dir_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_at(0, F_OE,   8'h00, "mid_rst_oe");
        expect_at(0, F_IE,   8'hFF, "mid_rst_ie");
        expect_at(0, F_DRDY, 8'h01, "mid_rst_drdy");
        expect_at(0, F_IN,   8'h00, "mid_rst_in");
        expect_at(0, F_A,    8'h00, "mid_rst_a");
        expect_at(0, F_DS0,  8'hFF, "mid_rst_ds0");
        expect_at(0, F_DS1,  8'h00, "mid_rst_ds1");
        expect_at(1, F_OE,   8'h00, "mid_rst_oe_held");
        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        // Fresh turnaround after reset gets full dead time
        bus.dir_valid = 1'b1;
        bus.dir_req   = 1'b1;
        expect_at(1, F_IE,   8'h00, "post_ie_k");
        expect_at(1, F_OE,   8'h00, "post_oe_k");
        expect_at(2, F_OE,   8'h00, "post_oe_k1");
        expect_at(2, F_DRDY, 8'h00, "post_drdy_k1");
        expect_at(3, F_OE,   8'hFF, "post_oe_k2");
        expect_at(3, F_A,    8'h5A, "post_a_k2");
        step();
        bus.dir_valid = 1'b0;
        repeat (6) step();

        foreach (sb[i]) begin
            tests++;
            failed++;
            $display("FAIL %s: never checked, want %h", sb[i].n, sb[i].v);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
